// File: rtl/conv_col_loader.sv
// conv_col_loader: write-side feeder for the convolution ping-pong bank.
// Takes a column-major pixel stream, gathers each column into an
// IMAGE_SIZE-wide vector, strobes it into the bank one cycle after the
// column's last pixel, then pulses ready once a whole frame has landed.
module conv_col_loader #(
  parameter int IMAGE_SIZE  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_SIZE   = 4,
  parameter int MAX_ADDRESS = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_out [0:IMAGE_SIZE-1],
  output logic                  wr_en,
  output logic [ADDR_SIZE-1:0]  col_idx,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int ROW_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMAGE_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] COL_LAST = ADDR_SIZE'(MAX_ADDRESS);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [ADDR_SIZE-1:0]  col_cnt_q, col_cnt_d;
  logic [ADDR_SIZE-1:0]  col_idx_q, col_idx_d;
  logic                  wr_en_q, wr_en_d;
  logic                  last_wr_q, last_wr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] shadow_q   [0:IMAGE_SIZE-1];
  logic [DATA_WIDTH-1:0] shadow_d   [0:IMAGE_SIZE-1];
  logic [DATA_WIDTH-1:0] data_out_q [0:IMAGE_SIZE-1];
  logic [DATA_WIDTH-1:0] data_out_d [0:IMAGE_SIZE-1];

  logic xfer;
  logic row_end;
  logic frame_end;
  logic early_last;

  assign xfer       = s_valid & s_ready;
  assign row_end    = (row_cnt_q == ROW_LAST);
  assign frame_end  = xfer & row_end & (col_cnt_q == COL_LAST);
  // s_last anywhere other than the frame's final pixel aborts the frame.
  assign early_last = xfer & s_last & ~(row_end & (col_cnt_q == COL_LAST));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_load) state_d = FILL;
      FILL:    if (early_last || frame_end) state_d = DONE;
      DONE:    if (start_load) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the stream is only accepted while filling
  always_comb begin
    s_ready = (state_q == FILL);
    busy    = (state_q == FILL);
  end

  // Datapath next values: counters, shadow capture, column assembly, flags
  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    col_idx_d = col_idx_q;
    wr_en_d   = 1'b0;
    last_wr_d = 1'b0;
    ready_d   = last_wr_q;   // ready trails the final column write by one cycle
    err_d     = err_q;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      shadow_d[i]   = shadow_q[i];
      data_out_d[i] = data_out_q[i];
    end

    if (state_q != FILL) begin
      if (start_load) begin
        row_cnt_d = '0;
        col_cnt_d = '0;
        err_d     = 1'b0;
      end
    end else if (xfer) begin
      if (early_last) begin
        // Partial column is dropped; already-written columns stay in the bank.
        err_d = 1'b1;
      end else begin
        shadow_d[row_cnt_q] = s_data;
        if (row_end) begin
          row_cnt_d = '0;
          col_cnt_d = col_cnt_q + ADDR_SIZE'(1);
          wr_en_d   = 1'b1;
          col_idx_d = col_cnt_q;
          // Rows 0..N-2 come from the shadow; the completing pixel bypasses it.
          for (int i = 0; i < IMAGE_SIZE - 1; i++) data_out_d[i] = shadow_q[i];
          data_out_d[IMAGE_SIZE-1] = s_data;
          if (frame_end) begin
            last_wr_d = 1'b1;
            if (!s_last) err_d = 1'b1;
          end
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end
    end
  end

  // Control and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      col_idx_q <= '0;
      wr_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      col_idx_q <= col_idx_d;
      wr_en_q   <= wr_en_d;
      last_wr_q <= last_wr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < IMAGE_SIZE; gi++) begin : g_lane
      // Per-row shadow and output column registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q[gi]   <= '0;
          data_out_q[gi] <= '0;
        end else begin
          shadow_q[gi]   <= shadow_d[gi];
          data_out_q[gi] <= data_out_d[gi];
        end
      end
      assign data_out[gi] = data_out_q[gi];
    end
  endgenerate

  assign wr_en   = wr_en_q;
  assign col_idx = col_idx_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: tb/tb_conv_col_loader.sv
// Scoreboard bench for conv_col_loader: the driver pushes expected column
// writes and ready pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_conv_col_loader;

  localparam int IS = 16;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] data_out [0:IS-1];
  logic          wr_en;
  logic [AW-1:0] col_idx;
  logic          ready;
  logic          busy;
  logic          err;

  conv_col_loader #(.IMAGE_SIZE(IS), .DATA_WIDTH(DW), .ADDR_SIZE(AW), .MAX_ADDRESS(15)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .data_out(data_out),
    .wr_en(wr_en), .col_idx(col_idx), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    col;
    logic [31:0]      due;
    logic [IS*DW-1:0] d;
  } exp_t;

  exp_t wq[$];
  int   rq[$];
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   cyc       = 0;
  int   stalls    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [IS*DW-1:0] act, input logic [IS*DW-1:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [IS*DW-1:0] pack_out();
    logic [IS*DW-1:0] v;
    for (int i = 0; i < IS; i++) v[i*DW +: DW] = data_out[i];
    return v;
  endfunction

  // Monitor: every write strobe and ready pulse must match the scoreboard
  exp_t mon_e;
  int   mon_r;
  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        check_cnt++;
        $display("FAIL wr_unexpected: got write col_idx=%0d expected no write", col_idx);
      end else begin
        mon_e = wq.pop_front();
        $display("write col_idx=%0d cycle=%0d (expected col %0d cycle %0d)", col_idx, cyc, mon_e.col, mon_e.due);
        chk("wr_col_idx", 128'(col_idx), 128'(mon_e.col));
        chk("wr_data", pack_out(), mon_e.d);
        chk("wr_latency", 128'(cyc), 128'(mon_e.due));
      end
    end
    if (ready) begin
      chk("ready_not_with_wr", 128'(wr_en), 128'(0));
      if (rq.size() == 0) begin
        check_cnt++;
        $display("FAIL ready_unexpected: got ready=1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_r = rq.pop_front();
        $display("ready pulse cycle=%0d (expected %0d)", cyc, mon_r);
        chk("ready_cycle", 128'(cyc), 128'(mon_r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  // Offer one pixel and hold it until it is taken (bounded)
  task automatic send(input logic [DW-1:0] d, input logic last, output bit ok);
    int w;
    w = 0;
    ok = 1'b1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready) begin
      w++;
      stalls++;
      if (w > 50) begin
        check_cnt++;
        $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", w);
        ok = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Stream pixels value=col*16+row; last_idx = pixel carrying s_last (-1: none)
  task automatic run_frame(input bit gap, input int last_idx, input bit spur, input int npix);
    exp_t e;
    bit   ok;
    int   c;
    int   r;
    for (int p = 0; p < npix; p++) begin
      c = p / IS;
      r = p % IS;
      if (spur && p == 50) start_load = 1'b1;
      send(DW'(c * IS + r), (p == last_idx), ok);
      start_load = 1'b0;
      if (!ok) return;
      if (p == last_idx && p != IS * IS - 1) return;
      if (r == IS - 1) begin
        e.col = AW'(c);
        e.due = 32'(cyc);
        for (int i = 0; i < IS; i++) e.d[i*DW +: DW] = DW'(c * IS + i);
        wq.push_back(e);
        if (p == IS * IS - 1) rq.push_back(cyc + 1);
      end
      if (gap) tick();
    end
  endtask

  task automatic end_checks(input string tag, input logic exp_err);
    repeat (4) tick();
    chk({tag, "_drained"}, 128'(wq.size() + rq.size()), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
    chk({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic poke_valid(input string tag);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) begin
      tick();
      chk({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_col_idx", 128'(col_idx), 128'(0));
    chk("rst_data_out", pack_out(), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Valid in IDLE is ignored
    poke_valid("idle");

    // Full frame, continuous valid
    pulse_start();
    chk("full_busy", 128'(busy), 128'(1));
    stalls = 0;
    run_frame(1'b0, 255, 1'b0, 256);
    chk("full_no_stall", 128'(stalls), 128'(0));
    end_checks("full", 1'b0);

    // Valid in DONE is ignored
    poke_valid("done");

    // Gapped valid, with a stray start_load mid-frame
    pulse_start();
    run_frame(1'b1, 255, 1'b1, 256);
    end_checks("gapped", 1'b0);

    // Early s_last at pixel 37
    pulse_start();
    run_frame(1'b0, 37, 1'b0, 256);
    end_checks("early", 1'b1);

    // Restart clears err, frame completes
    pulse_start();
    chk("restart_err_clr", 128'(err), 128'(0));
    run_frame(1'b0, 255, 1'b0, 256);
    end_checks("restart", 1'b0);

    // Missing s_last
    pulse_start();
    run_frame(1'b0, -1, 1'b0, 256);
    end_checks("nolast", 1'b1);

    // Reset asynchronously after 100 pixels
    pulse_start();
    run_frame(1'b0, -1, 1'b0, 100);
    chk("pre_rst_col_idx", 128'(col_idx), 128'(5));
    #1 rst = 1'b1;
    #1;
    chk("arst_wr_en", 128'(wr_en), 128'(0));
    chk("arst_ready", 128'(ready), 128'(0));
    chk("arst_s_ready", 128'(s_ready), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_err", 128'(err), 128'(0));
    chk("arst_col_idx", 128'(col_idx), 128'(0));
    chk("arst_data_out", pack_out(), 128'(0));
    wq.delete();
    rq.delete();
    tick();
    rst = 1'b0;
    poke_valid("post_rst");
    pulse_start();
    run_frame(1'b0, 255, 1'b0, 256);
    end_checks("post_rst", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/conv_col_loader.md
Name: conv_col_loader

Overview:
- Write-side feeder for the convolution ping-pong memory bank.
- Accepts a serial pixel stream in column-major order: column 0 rows 0..IMAGE_SIZE-1, then column 1, and so on.
- Assembles each column into an IMAGE_SIZE-wide vector and issues a one-cycle write strobe, so bank element i receives row i at column address col_idx.
- After the last column it pulses the `ready` that starts the bank's read/convolution sequence.

Parameters:
- IMAGE_SIZE, 16, pixels per column = number of bank elements
- DATA_WIDTH, 8, pixel width
- ADDR_SIZE, 4, column index width
- MAX_ADDRESS, 15, index of the last column in a frame

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start_load  in  1  one-cycle request to begin loading a frame
- s_valid  in  1  pixel valid
- s_data  in  DATA_WIDTH  pixel value
- s_last  in  1  marks the final pixel of the frame
- s_ready  out  1  loader accepts a pixel this cycle
- data_out  out  DATA_WIDTH x [0:IMAGE_SIZE-1]  assembled column, element i = row i
- wr_en  out  1  one-cycle column write strobe to the memory bank
- col_idx  out  ADDR_SIZE  column address belonging to the current data_out/wr_en
- ready  out  1  one-cycle frame-loaded pulse to the bank controller
- busy  out  1  high in FILL
- err  out  1  sticky framing error

Behaviour:
- Reset (async, rst=1): state=IDLE; row_cnt=0, col_cnt=0; s_ready=0, wr_en=0, ready=0, busy=0, err=0; col_idx=0; data_out all 0; shadow register all 0.
- Handshake: a pixel transfers when s_valid & s_ready. s_ready is combinational = (state==FILL). It never depends on s_valid.
- IDLE:
  - start_load=1 -> FILL, with row_cnt=0, col_cnt=0, err=0.
  - Any other input is ignored.
- FILL:
  - Each transfer stores s_data into shadow[row_cnt] and increments row_cnt.
  - Transfer with row_cnt==IMAGE_SIZE-1: next cycle data_out = shadow rows 0..IMAGE_SIZE-2 plus this pixel at row IMAGE_SIZE-1; wr_en=1; col_idx=col_cnt; row_cnt wraps to 0; col_cnt increments.
  - Write latency is exactly 1 cycle after the column's final handshake.
  - data_out holds its value until the next column write.
  - No bubble: the first pixel of the next column is accepted in the same cycle as the column-completing handshake and in the wr_en cycle.
- Frame completion: the transfer with row_cnt==IMAGE_SIZE-1 and col_cnt==MAX_ADDRESS does all of the following.
  - Normal column write next cycle (wr_en=1, col_idx=MAX_ADDRESS).
  - State -> DONE; s_ready=0 from the wr_en cycle onward.
  - ready=1 exactly one cycle after that wr_en (wr_en and ready are never high together).
  - If s_last=0 on that pixel: err=1, but the frame is still written and ready still pulses.
- Early s_last (s_last=1 on any transfer that is not the frame's final pixel):
  - The partial column is discarded; no wr_en for it.
  - Columns already written are not retracted.
  - err=1, state -> DONE, ready is NOT pulsed.
- DONE:
  - s_ready=0.
  - start_load=1 -> FILL with counters cleared and err cleared.
  - data_out and col_idx retain their last values.
- start_load while in FILL: ignored; no counter reset.
- s_valid without s_ready: ignored; pixel not consumed.
- busy = (state==FILL).
- Counter widths:
  - row_cnt: clog2(IMAGE_SIZE) bits, with explicit compare to IMAGE_SIZE-1 (never relies on natural overflow).
  - col_cnt: ADDR_SIZE bits.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to reset values; the partial frame is lost; after release the block waits in IDLE for start_load.

Test Plan:
- Full frame, continuous valid:
  - Stimulus: start_load, then 256 pixels with value = col*16+row, s_last on pixel 255.
  - Required response:
    - 16 wr_en pulses spaced 16 cycles apart.
    - Pulse k has col_idx=k and data_out[i]=k*16+i.
    - First wr_en comes 1 cycle after pixel 15's handshake.
    - ready pulses once, 1 cycle after the col_idx=15 write; err=0; busy drops after the last pixel.
- Gapped valid:
  - Stimulus: same frame with s_valid toggling 1,0,1,0.
  - Required response: identical column contents and order; wr_en only after the 16th accepted pixel of each column; no duplicated or dropped pixels.
- Early s_last:
  - Stimulus: s_last asserted on pixel 37 (column 2, row 5).
  - Required response: exactly 2 wr_en pulses (col_idx 0, 1); no write for column 2; err=1; ready never pulses; s_ready=0 afterwards.
  - Follow-up: a new start_load clears err and a full frame completes normally.
- Missing s_last:
  - Stimulus: 256 pixels with s_last never asserted.
  - Required response: all 16 writes occur; ready pulses; err=1 after the final write.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (between clock edges) after 100 pixels.
  - Required response: wr_en, ready, s_ready, busy, err and data_out go to 0 without waiting for a clock edge.
  - Follow-up: after release, s_ready stays 0 until start_load; the next frame starts at col_idx=0, row 0.
- Spurious controls:
  - Stimulus: start_load pulsed mid-FILL; s_valid asserted in IDLE and DONE.
  - Required response: no counter reset; nothing accepted in IDLE/DONE; write sequence unchanged.
